// File: rtl/mae_sweep_engine.sv
// mae_sweep_engine
// Exhaustive error-characterisation harness for a combinational approximate
// multiplier. Walks every operand pair through the multiplier, registers the
// returned product, compares it against the exact product and accumulates
// sum / max / count of absolute error plus the first worst-case operand pair.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        begin a sweep (IDLE only) / terminate a sweep
//   a_out, b_out        operands driven to the multiplier under test
//   approx_in           product returned combinationally by the multiplier
//   busy, done          sweep in progress / one-cycle completion pulse
//   results_valid       results reflect a completed sweep
//   sum_err, max_err    sum and maximum of |approx - exact|
//   err_cnt             number of pairs with nonzero error
//   mae_int             sum_err >> PW (integer MAE over all pairs)
//   wc_a, wc_b          first operand pair reaching max_err

module mae_sweep_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PW    = 2 * WIDTH,
    parameter int unsigned SUM_W = 4 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [PW-1:0]    approx_in,
    output logic             busy,
    output logic             done,
    output logic             results_valid,
    output logic [SUM_W-1:0] sum_err,
    output logic [PW-1:0]    max_err,
    output logic [PW:0]      err_cnt,
    output logic [PW-1:0]    mae_int,
    output logic [WIDTH-1:0] wc_a,
    output logic [WIDTH-1:0] wc_b
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      cnt_q, cnt_d;

    // S1: operands and returned product
    logic               s1_v_q, s1_v_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [PW-1:0]      s1_p_q, s1_p_d;

    // S2: absolute error and its operands
    logic               s2_v_q, s2_v_d;
    logic [PW-1:0]      s2_diff_q, s2_diff_d;
    logic [WIDTH-1:0]   s2_a_q, s2_a_d;
    logic [WIDTH-1:0]   s2_b_q, s2_b_d;

    // S3: accumulators
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [PW-1:0]      max_q, max_d;
    logic [PW:0]        ecnt_q, ecnt_d;
    logic [WIDTH-1:0]   wca_q, wca_d;
    logic [WIDTH-1:0]   wcb_q, wcb_d;
    logic               rv_q, rv_d;

    logic [PW-1:0]      exact;
    logic [PW:0]        dfull;
    logic [PW:0]        dneg;
    logic               flush;
    logic [SUM_W-1:0]   sum_shift;

    // Exact product and |approx - exact| in PW+1-bit two's complement.
    always_comb begin
        exact = {{(PW - WIDTH){1'b0}}, s1_a_q} * {{(PW - WIDTH){1'b0}}, s1_b_q};
        dfull = {1'b0, s1_p_q} - {1'b0, exact};
        dneg  = ~dfull + {{PW{1'b0}}, 1'b1};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush     = 1'b0;
        rv_d      = rv_q;

        s1_v_d    = 1'b0;
        s1_a_d    = cnt_q[PW-1:WIDTH];
        s1_b_d    = cnt_q[WIDTH-1:0];
        s1_p_d    = approx_in;

        s2_v_d    = s1_v_q;
        s2_diff_d = dfull[PW] ? dneg[PW-1:0] : dfull[PW-1:0];
        s2_a_d    = s1_a_q;
        s2_b_d    = s1_b_q;

        sum_d     = sum_q;
        max_d     = max_q;
        ecnt_d    = ecnt_q;
        wca_d     = wca_q;
        wcb_d     = wcb_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    rv_d    = 1'b0;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    flush   = 1'b1;
                end else begin
                    s1_v_d = 1'b1;
                    if (cnt_q == '1) begin
                        // Last pair issued; counter parks at zero.
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + {{(PW - 1){1'b0}}, 1'b1};
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                    flush   = 1'b1;
                end else if (!s1_v_q && !s2_v_q) begin
                    state_d = StDone;
                    rv_d    = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush) begin
            s2_v_d = 1'b0;
        end

        // Accumulation; an aborting edge freezes the partial results.
        if (s2_v_q && !flush) begin
            sum_d = sum_q + SUM_W'(s2_diff_q);
            if (s2_diff_q != '0) begin
                ecnt_d = ecnt_q + {{PW{1'b0}}, 1'b1};
            end
            if (s2_diff_q > max_q) begin
                max_d = s2_diff_q;
                wca_d = s2_a_q;
                wcb_d = s2_b_q;
            end
        end

        // Start clears the accumulators (pipeline is empty in IDLE).
        if (state_q == StIdle && start) begin
            sum_d  = '0;
            max_d  = '0;
            ecnt_d = '0;
            wca_d  = '0;
            wcb_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_p_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_diff_q <= '0;
            s2_a_q    <= '0;
            s2_b_q    <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            ecnt_q    <= '0;
            wca_q     <= '0;
            wcb_q     <= '0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_p_q    <= s1_p_d;
            s2_v_q    <= s2_v_d;
            s2_diff_q <= s2_diff_d;
            s2_a_q    <= s2_a_d;
            s2_b_q    <= s2_b_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            ecnt_q    <= ecnt_d;
            wca_q     <= wca_d;
            wcb_q     <= wcb_d;
            rv_q      <= rv_d;
        end
    end

    always_comb begin
        sum_shift = sum_q >> PW;
        mae_int   = sum_shift[PW-1:0];
    end

    assign a_out         = cnt_q[PW-1:WIDTH];
    assign b_out         = cnt_q[WIDTH-1:0];
    assign busy          = (state_q == StRun) || (state_q == StDrain);
    assign done          = (state_q == StDone);
    assign results_valid = rv_q;
    assign sum_err       = sum_q;
    assign max_err       = max_q;
    assign err_cnt       = ecnt_q;
    assign wc_a          = wca_q;
    assign wc_b          = wcb_q;

endmodule

// File: tb/tb_mae_sweep_engine.sv
// Testbench for mae_sweep_engine at WIDTH=4 (256 pairs, done 259 edges after start).
module tb_mae_sweep_engine;

    localparam int W  = 4;
    localparam int PW = 2 * W;
    localparam int SW = 4 * W;
    localparam int N  = 1 << (2 * W);
    localparam int M  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  a_out, b_out;
    logic [PW-1:0] approx_in;
    logic          busy, done, results_valid;
    logic [SW-1:0] sum_err;
    logic [PW-1:0] max_err;
    logic [PW:0]   err_cnt;
    logic [PW-1:0] mae_int;
    logic [W-1:0]  wc_a, wc_b;

    int mode = 0;
    int tests = 0;
    int fails = 0;

    // Reference accumulators over the pairs retired so far.
    longint m_sum, m_max, m_cnt;
    int     m_wca, m_wcb;

    mae_sweep_engine #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .a_out         (a_out),
        .b_out         (b_out),
        .approx_in     (approx_in),
        .busy          (busy),
        .done          (done),
        .results_valid (results_valid),
        .sum_err       (sum_err),
        .max_err       (max_err),
        .err_cnt       (err_cnt),
        .mae_int       (mae_int),
        .wc_a          (wc_a),
        .wc_b          (wc_b)
    );

    always #5 clk = ~clk;

    // Multiplier stubs: 0 exact, 1 exact^1, 2 exact except 0 at (M,M).
    function automatic int stub(int m, int a, int b);
        int e;
        e = a * b;
        case (m)
            1:       return e ^ 1;
            2:       return (a == M && b == M) ? 0 : e;
            default: return e;
        endcase
    endfunction

    always_comb approx_in = PW'(stub(mode, int'(a_out), int'(b_out)));

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sum = 0; m_max = 0; m_cnt = 0; m_wca = 0; m_wcb = 0;
    endtask

    task automatic model_pair(input int j);
        int a, b, e, p;
        longint d;
        a = j >> W;
        b = j & M;
        e = a * b;
        p = stub(mode, a, b);
        d = (p > e) ? longint'(p - e) : longint'(e - p);
        m_sum += d;
        if (d != 0) m_cnt++;
        if (d > m_max) begin
            m_max = d; m_wca = a; m_wcb = b;
        end
    endtask

    // Expected state k edges after the edge that sampled start.
    task automatic check_cycle(input int k);
        int pair;
        pair = (k < N) ? k : 0;
        chk($sformatf("busy@%0d", k), busy, (k <= N + 2) ? 1 : 0);
        chk($sformatf("done@%0d", k), done, (k == N + 3) ? 1 : 0);
        chk($sformatf("rv@%0d", k), results_valid, (k >= N + 3) ? 1 : 0);
        chk($sformatf("a_out@%0d", k), a_out, pair >> W);
        chk($sformatf("b_out@%0d", k), b_out, pair & M);
        chk($sformatf("sum@%0d", k), sum_err, m_sum);
        chk($sformatf("max@%0d", k), max_err, m_max);
        chk($sformatf("cnt@%0d", k), err_cnt, m_cnt);
        chk($sformatf("mae@%0d", k), mae_int, m_sum >> PW);
        chk($sformatf("wca@%0d", k), wc_a, m_wca);
        chk($sformatf("wcb@%0d", k), wc_b, m_wcb);
    endtask

    // Start a sweep and track it for stop_at edges (negative: to completion).
    task automatic run_sweep(input int m, input bit pulse, input int stop_at);
        int last;
        last = (stop_at < 0) ? N + 3 : stop_at;
        @(negedge clk);
        mode = m;
        model_reset();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_cycle(0);
        for (int k = 1; k <= last; k++) begin
            start = pulse && (k <= N + 2) && (k % 5 == 0);
            @(posedge clk);
            @(negedge clk);
            if (k >= 3 && k - 3 < N) model_pair(k - 3);
            check_cycle(k);
        end
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, a_out, 0);
        chk({tag, "_b"}, b_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rv"}, results_valid, 0);
        chk({tag, "_sum"}, sum_err, 0);
        chk({tag, "_max"}, max_err, 0);
        chk({tag, "_cnt"}, err_cnt, 0);
        chk({tag, "_mae"}, mae_int, 0);
        chk({tag, "_wca"}, wc_a, 0);
        chk({tag, "_wcb"}, wc_b, 0);
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        int nd, nb;
        nd = 0; nb = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        chk({tag, "_done_pulses"}, nd, 0);
        chk({tag, "_busy_cycles"}, nb, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Exact stub with start pulsed during the sweep.
        run_sweep(0, 1'b1, -1);
        chk("exact_sum", sum_err, 0);
        chk("exact_max", max_err, 0);
        chk("exact_cnt", err_cnt, 0);
        chk("exact_rv", results_valid, 1);
        @(negedge clk);
        chk("hold_done", done, 0);
        chk("hold_busy", busy, 0);
        chk("hold_rv", results_valid, 1);

        // Off-by-one on every product.
        run_sweep(1, 1'b0, -1);
        chk("xor_sum", sum_err, 256);
        chk("xor_cnt", err_cnt, 256);
        chk("xor_max", max_err, 1);
        chk("xor_mae", mae_int, 1);
        chk("xor_wca", wc_a, 0);
        chk("xor_wcb", wc_b, 0);

        // Single corner error.
        run_sweep(2, 1'b0, -1);
        chk("corner_max", max_err, 225);
        chk("corner_sum", sum_err, 225);
        chk("corner_cnt", err_cnt, 1);
        chk("corner_wca", wc_a, 15);
        chk("corner_wcb", wc_b, 15);
        chk("corner_mae", mae_int, 0);

        // Abort mid-RUN, then a clean sweep.
        run_sweep(0, 1'b0, 100);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rv", results_valid, 0);
        watch_idle("abort", 300);
        chk("abort_rv_after", results_valid, 0);
        run_sweep(0, 1'b0, -1);
        chk("post_abort_sum", sum_err, 0);
        chk("post_abort_rv", results_valid, 1);

        // Asynchronous reset while draining.
        run_sweep(1, 1'b0, N + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("drain_rst");
        @(negedge clk);
        rst_n = 1'b1;
        watch_idle("post_rst", 300);
        chk("post_rst_rv", results_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mae_sweep_engine.md
Name: mae_sweep_engine

Overview:
- Exhaustive error-characterisation harness that sits directly around a combinational approximate multiplier of the Dadda/ripple-carry family.
- Drives every operand pair to the multiplier, registers the product it returns, and compares it against an internally computed exact product.
- Accumulates sum of absolute error, maximum error, error count and worst-case operands.
- Feeds pwr-mae characterisation of each generated multiplier in simulation/FPGA.

Parameters:
- WIDTH, 8, operand width of the multiplier under test.
- PW, 2*WIDTH, product width.
- SUM_W, 4*WIDTH, width of the absolute-error sum (no overflow possible).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a sweep (sampled only in IDLE).
- abort  in  1  terminate the sweep, return to IDLE.
- a_out  out  WIDTH  operand 1 to the multiplier under test (IN1).
- b_out  out  WIDTH  operand 2 to the multiplier under test (IN2).
- approx_in  in  PW  product returned combinationally by the multiplier (Out).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- results_valid  out  1  results reflect a completed sweep.
- sum_err  out  SUM_W  Σ|approx−exact|.
- max_err  out  PW  maximum |approx−exact|.
- err_cnt  out  PW+1  number of pairs with nonzero error.
- mae_int  out  PW  sum_err >> PW (integer MAE over 2^PW pairs).
- wc_a, wc_b  out  WIDTH each  first operand pair reaching max_err.

Behaviour:
- Reset (rst_n low, any time, including mid-sweep):
  - State goes to IDLE.
  - All outputs are 0: a_out, b_out, busy, done, results_valid, sum_err, max_err, err_cnt, wc_a, wc_b.
  - Pipeline valid bits are cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → RUN.
  - On that edge: clear the accumulators, clear results_valid, set the pair counter to 0.
- RUN:
  - Pair counter is 2*WIDTH bits; a_out = counter[2W-1:W], b_out = counter[W-1:0].
  - a_out and b_out are register outputs.
  - Counter increments by 1 every cycle.
  - When the counter equals all-ones, the last pair is issued; counter wraps to 0 and holds, next state DRAIN.
- Pipeline, one pair per cycle, no stalls:
  - S1: on each RUN edge, capture {a_out, b_out, approx_in, v=1}. approx_in is sampled in the same cycle a_out/b_out are presented (multiplier is purely combinational).
  - S2: exact = a*b (PW bits); diff = |approx − exact| computed in PW+1-bit signed, result PW bits; register {diff, a, b, v}.
  - S3, when v: sum_err += diff; if diff≠0 then err_cnt += 1; if diff > max_err (strictly greater) then max_err=diff, wc_a=a, wc_b=b.
- DRAIN: wait until the S1 and S2 valid bits are both 0 → DONE.
- DONE: one cycle; done=1, results_valid=1 → IDLE.
- Done timing: done is high exactly 2^(2W)+3 edges after the edge that sampled start.
- Outputs hold their values in IDLE until the next start.
- mae_int is combinational from sum_err.
- start in RUN/DRAIN/DONE is ignored.
- abort (RUN or DRAIN): next edge → IDLE; pipeline valids cleared; done not pulsed; results_valid stays 0; accumulators hold partial values. abort in IDLE is ignored. abort and start together in IDLE: start wins.
- busy = (state==RUN || state==DRAIN).
- Width rules:
  - sum_err maximum is 2^(2W)·(2^(2W)−1) < 2^SUM_W.
  - err_cnt maximum is 2^(2W), which needs PW+1 bits.
  - No saturation logic is required.

Test Plan:
- Exact stub (approx_in = a_out*b_out), start → done after 65539 edges: sum_err=0, max_err=0, err_cnt=0, mae_int=0, results_valid=1.
- Stub approx_in = exact ^ 1: sum_err=65536, err_cnt=65536, max_err=1, mae_int=1, wc_a=0, wc_b=0.
- Stub approx_in = exact except 0 when a=255,b=255: max_err=65025, sum_err=65025, err_cnt=1, wc_a=255, wc_b=255.
- Abort after 1000 RUN cycles: next cycle busy=0, state IDLE; done never pulses; results_valid=0. A subsequent start completes normally with the exact-stub results.
- start pulsed repeatedly during RUN: no restart; done occurs once at 65539 edges after the first start.
- rst_n low mid-DRAIN: all outputs 0 immediately (asynchronous). After release, idle with no done pulse until a new start.
